// File: rtl/ddr_bram_responder.sv
// Host-side ddr_if responder backed by a block-RAM array of 64-bit words.
// Handles burst writes with byte enables and gap-free burst reads.
module ddr_bram_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        acquire,
  input  logic [28:0] addr,
  input  logic [63:0] wdata,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  burstcnt,
  input  logic [7:0]  byteenable,
  output logic [63:0] rdata,
  output logic        busy,
  output logic        rdata_ready
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_ISSUE, READ_DATA} state_t;

  logic [63:0]          mem [DEPTH];
  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [63:0]          rdata_q;
  logic                 rdata_ready_q, rdata_ready_d;
  logic                 rd_en;
  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  logic                 idle_like;
  logic [ADDR_BITS-1:0] addr_lo;
  logic [7:0]           burst_eff;
  logic                 unused_addr_hi;

  assign addr_lo        = addr[ADDR_BITS-1:0];
  assign burst_eff      = (burstcnt == 8'd0) ? 8'd1 : burstcnt;
  assign unused_addr_hi = ^addr[28:ADDR_BITS];

  // The last read beat behaves like IDLE so a new request is taken on its edge.
  assign idle_like = (state_q == IDLE) || ((state_q == READ_DATA) && (cnt_q == 8'd0));

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (byteenable[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      base_q        <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      cnt_q         <= cnt_d;
      rdata_ready_q <= rdata_ready_d;
      if (rd_en) rdata_q <= mem[base_q];
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    cnt_d         = cnt_q;
    rdata_ready_d = 1'b0;
    rd_en         = 1'b0;
    we            = 1'b0;
    waddr         = base_q;
    if ((state_q == READ_ISSUE) || ((state_q == READ_DATA) && (cnt_q != 8'd0))) begin
      rd_en         = 1'b1;
      rdata_ready_d = 1'b1;
      base_d        = base_q + 1'b1;
      cnt_d         = cnt_q - 8'd1;
      state_d       = READ_DATA;
    end else if (idle_like) begin
      state_d = IDLE;
      if (acquire && write) begin
        we      = 1'b1;
        waddr   = addr_lo;
        base_d  = addr_lo + 1'b1;
        cnt_d   = burst_eff - 8'd1;
        state_d = (burst_eff == 8'd1) ? IDLE : WRITE_BURST;
      end else if (acquire && read) begin
        base_d  = addr_lo;
        cnt_d   = burst_eff;
        state_d = READ_ISSUE;
      end
    end else if (state_q == WRITE_BURST) begin
      if (write) begin
        we     = 1'b1;
        base_d = base_q + 1'b1;
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = IDLE;
      end
    end
  end

  always_comb begin
    busy        = (state_q == READ_ISSUE) || ((state_q == READ_DATA) && (cnt_q != 8'd0));
    rdata       = rdata_q;
    rdata_ready = rdata_ready_q;
  end

endmodule
